// File: rtl/periph_timer.sv
// periph_timer: memory-mapped reload timer with interrupt plus a free-running
// cycle counter (Systick). Register reads are combinational and zero-latency;
// all state updates happen on the rising clock edge.
module periph_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  output logic        Hit,
  output logic [31:0] Systick,
  output logic        irq
);

  localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
  localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
  localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0014;

  localparam logic [31:0] TL_MAX = 32'hFFFF_FFFF;

  // TCON bit positions
  localparam int EN_BIT = 0;
  localparam int IE_BIT = 1;
  localparam int IS_BIT = 2;

  logic [31:0] th_r;
  logic [31:0] tl_r;
  logic [2:0]  tcon_r;
  logic [31:0] systick_r;
  logic        irq_r;

  logic        sel_th_s;
  logic        sel_tl_s;
  logic        sel_tcon_s;
  logic        sel_systick_s;
  logic        wr_th_s;
  logic        wr_tl_s;
  logic        wr_tcon_s;
  logic        overflow_s;
  logic        reload_s;
  logic [31:0] th_nxt_s;
  logic [31:0] tl_nxt_s;
  logic [2:0]  tcon_nxt_s;

  // Exact-match decode: any nonzero Address[1:0] misses every register.
  assign sel_th_s      = (Address == ADDR_TH);
  assign sel_tl_s      = (Address == ADDR_TL);
  assign sel_tcon_s    = (Address == ADDR_TCON);
  assign sel_systick_s = (Address == ADDR_SYSTICK);
  assign Hit           = sel_th_s | sel_tl_s | sel_tcon_s | sel_systick_s;

  // Systick is read-only, so it has no write strobe.
  assign wr_th_s   = MemWrite & sel_th_s;
  assign wr_tl_s   = MemWrite & sel_tl_s;
  assign wr_tcon_s = MemWrite & sel_tcon_s;

  // A bus write to TL pre-empts the reload, so no interrupt is raised then.
  assign overflow_s = tcon_r[EN_BIT] & (tl_r == TL_MAX);
  assign reload_s   = overflow_s & ~wr_tl_s;

  assign Systick = systick_r;
  assign irq     = irq_r;

  // Combinational read mux; returns pre-write values during a read+write.
  always_comb begin
    Read_data = 32'h0;
    if (MemRead && Hit) begin
      if (sel_th_s) begin
        Read_data = th_r;
      end else if (sel_tl_s) begin
        Read_data = tl_r;
      end else if (sel_tcon_s) begin
        Read_data = {29'h0, tcon_r};
      end else begin
        Read_data = systick_r;
      end
    end else begin
      Read_data = 32'h0;
    end
  end

  // Next-state for TH/TL/TCON: bus write beats count, overflow set beats IS clear.
  always_comb begin
    th_nxt_s   = th_r;
    tl_nxt_s   = tl_r;
    tcon_nxt_s = tcon_r;

    if (wr_th_s) begin
      th_nxt_s = Write_data;
    end else begin
      th_nxt_s = th_r;
    end

    // Reload uses the old TH even if TH is being written on the same edge.
    if (wr_tl_s) begin
      tl_nxt_s = Write_data;
    end else if (reload_s) begin
      tl_nxt_s = th_r;
    end else if (tcon_r[EN_BIT]) begin
      tl_nxt_s = tl_r + 32'd1;
    end else begin
      tl_nxt_s = tl_r;
    end

    if (wr_tcon_s) begin
      tcon_nxt_s[EN_BIT] = Write_data[EN_BIT];
      tcon_nxt_s[IE_BIT] = Write_data[IE_BIT];
    end else begin
      tcon_nxt_s[EN_BIT] = tcon_r[EN_BIT];
      tcon_nxt_s[IE_BIT] = tcon_r[IE_BIT];
    end

    // IS is write-0-to-clear; a simultaneous overflow keeps it set.
    if (reload_s && tcon_r[IE_BIT]) begin
      tcon_nxt_s[IS_BIT] = 1'b1;
    end else if (wr_tcon_s && !Write_data[IS_BIT]) begin
      tcon_nxt_s[IS_BIT] = 1'b0;
    end else begin
      tcon_nxt_s[IS_BIT] = tcon_r[IS_BIT];
    end
  end

  // Timer register update, with reset overriding bus writes and counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      th_r   <= 32'h0;
      tl_r   <= 32'h0;
      tcon_r <= 3'b000;
      irq_r  <= 1'b0;
    end else begin
      th_r   <= th_nxt_s;
      tl_r   <= tl_nxt_s;
      tcon_r <= tcon_nxt_s;
      // Registered from next-state so irq tracks IS & IE with no bus-to-output path.
      irq_r  <= tcon_nxt_s[IS_BIT] & tcon_nxt_s[IE_BIT];
    end
  end

  // Free-running cycle counter, independent of the timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      systick_r <= 32'h0;
    end else begin
      systick_r <= systick_r + 32'd1;
    end
  end

endmodule

// File: doc/periph_timer.md
PERIPH_TIMER -- requirements
Module: periph_timer

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 MemRead  input  1  bus read strobe from the MEM stage.
REQ-005 MemWrite  input  1  bus write strobe from the MEM stage.
REQ-006 Address  input  32  byte address of the bus access.
REQ-007 Write_data  input  32  bus write data.
REQ-008 Read_data  output  32  read data for a hit, else 32'h0.
REQ-009 Hit  output  1  Address decodes to a register in this block.
REQ-010 Systick  output  32  free-running cycle counter value.
REQ-011 irq  output  1  timer interrupt request.

Function
REQ-012 The block SHALL decode the following word addresses, with Address[1:0] required to be 2'b00:
- 32'h40000000 TH (reload value, R/W)
- 32'h40000004 TL (count value, R/W)
- 32'h40000008 TCON (R/W, bits [2:0]; [31:3] read 0)
- 32'h40000014 Systick (read-only)
REQ-013 Hit SHALL be combinational and 1 only for an exact match on one of the four addresses; 0x4000000C and 0x40000010 belong to other blocks and SHALL give Hit=0.
REQ-014 Read_data SHALL be combinational: the selected register when MemRead=1 and Hit=1, else 32'h0; zero-latency, no wait states.
REQ-015 Writes SHALL take effect at the rising edge where MemWrite=1 and Hit=1; the new value is visible on the next cycle.
REQ-016 Writes to Systick and writes with Address[1:0]!=0 SHALL be ignored.
REQ-017 TCON fields:
- bit0 EN: count enable
- bit1 IE: interrupt enable
- bit2 IS: interrupt status; a write of 0 clears it, a write of 1 leaves it unchanged
REQ-018 When EN=1 and no TL write occurs in the cycle, TL SHALL increment by 1 per clock.
REQ-019 When EN=1 and TL=32'hFFFFFFFF, the next TL SHALL be TH (reload), not 0.
REQ-020 On that reload edge, if IE=1, IS SHALL be set to 1.
REQ-021 If IE=0, overflow SHALL reload TL without setting IS.
REQ-022 When EN=0, TL SHALL hold its value.
REQ-023 If a bus write to TL coincides with an increment or reload, the bus write SHALL win.
REQ-024 If a bus write to TH coincides with a reload, TL SHALL load the old TH, and TH SHALL take the new value.
REQ-025 If a TCON write clearing IS coincides with an overflow that sets IS, IS SHALL end at 1, so no interrupt is lost.
- EN and IE SHALL take the written values in that cycle.
REQ-026 A TCON write that sets EN SHALL start counting on the following edge, not on the write edge.
REQ-027 irq SHALL equal IS & IE, registered-derived with no combinational path from the bus inputs.
REQ-028 The Systick register SHALL increment by 1 every clock and wrap 32'hFFFFFFFF -> 0.
- The Systick output SHALL present the register value directly.
- Systick is unaffected by the timer state.
REQ-029 MemRead and MemWrite asserted together to the same address SHALL return the pre-write value on Read_data and perform the write.

Reset
REQ-030 While reset=1 at a clock edge, TH, TL, TCON and Systick SHALL all become 32'h0 in that cycle.
REQ-031 Reset SHALL override any simultaneous bus write or count.
REQ-032 After reset, irq SHALL be 0 and Hit/Read_data SHALL depend only on the bus inputs.
REQ-033 Reset asserted mid-count SHALL abort the count with no reload and no IS set on that edge.

Verification
REQ-034 Reset, then idle 5 cycles with a read of 0x40000014 -> Read_data=5 and Hit=1; a read of 0x4000000C -> Hit=0 and Read_data=0.
REQ-035 Write TH=32'hFFFFFFF0, TL=32'hFFFFFFFE, TCON=3'b011 -> after 2 counting edges TL=32'hFFFFFFF0, IS=1, irq=1.
REQ-036 With IS=1, write TCON=3'b011 on the same edge as the next overflow -> IS remains 1; a later write of TCON=3'b011 with no overflow -> IS=0 and irq=0.
REQ-037 With EN=1 and TL=32'h10, write TL=32'h100 -> next cycle TL=32'h100 (not 32'h11), then 32'h101.
REQ-038 Write to Systick, then write to 0x40000001 -> Systick keeps counting and no register changes.
REQ-039 Assert reset during counting with TL=32'hFFFFFFFF -> TL=0, TCON=0, Systick=0, irq=0 on the next cycle.
